// File: rtl/balance_pkg.sv
// Shared types and helpers for the balance controller: power/rider states,
// steering pot clip constants and signed saturation helpers.
package balance_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        SOFT = 2'd1,
        RUN  = 2'd2,
        DROP = 2'd3
    } bal_state_t;

    localparam logic [11:0] STEER_MIN = 12'h200;
    localparam logic [11:0] STEER_MAX = 12'hE00;
    localparam logic [11:0] STEER_MID = 12'h7FF;

    // Clamp a signed value into the range of a w-bit signed number.
    function automatic logic signed [31:0] sat_s(input logic signed [31:0] x, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (x > hi)
            return hi;
        if (x < lo)
            return lo;
        return x;
    endfunction

    // Magnitude that stays representable in w bits (most-negative maps to max positive).
    function automatic logic signed [31:0] abs_sat(input logic signed [31:0] x, input int w);
        return sat_s((x < 0) ? -x : x, w);
    endfunction

endpackage

// File: rtl/balance_cntrl_param_if.sv
// Sensor-in / motor-out bundle of the balance controller.
interface balance_cntrl_param_if #(
    parameter int PTCH_W = 16,
    parameter int SPD_W  = 12,
    parameter int SS_W   = 9
);
    logic                     vld;
    logic signed [PTCH_W-1:0] ptch;
    logic signed [PTCH_W-1:0] ptch_rt;
    logic                     pwr_up;
    logic                     rider_off;
    logic [11:0]              steer_pot;
    logic                     en_steer;
    logic signed [SPD_W-1:0]  lft_spd;
    logic signed [SPD_W-1:0]  rght_spd;
    logic                     spd_vld;
    logic                     too_fast;
    logic [SS_W-1:0]          ss_tmr;

    modport master (
        output vld, ptch, ptch_rt, pwr_up, rider_off, steer_pot, en_steer,
        input  lft_spd, rght_spd, spd_vld, too_fast, ss_tmr
    );

    modport slave (
        input  vld, ptch, ptch_rt, pwr_up, rider_off, steer_pot, en_steer,
        output lft_spd, rght_spd, spd_vld, too_fast, ss_tmr
    );
endinterface

// File: rtl/bal_soft_start.sv
// Power/rider state machine with the soft-start gain ramp (ss_tmr) and its step prescaler.
module bal_soft_start
    import balance_pkg::*;
#(
    parameter int SS_W     = 9,
    parameter bit FAST_SIM = 1'b1
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            pwr_up,
    input  logic            rider_off,
    output bal_state_t      state,
    output logic [SS_W-1:0] ss_tmr
);

    localparam logic [SS_W-1:0] SS_MAX = '1;
    localparam logic [SS_W-1:0] SS_ONE = {{(SS_W-1){1'b0}}, 1'b1};

    bal_state_t      state_reg;
    logic [SS_W-1:0] ss_tmr_reg;
    logic [7:0]      prescale_reg;
    logic            step;

    assign step   = FAST_SIM ? 1'b1 : (prescale_reg == 8'hFF);
    assign state  = state_reg;
    assign ss_tmr = ss_tmr_reg;

    always_ff @(posedge clk) begin
        if (srst || !pwr_up) begin
            // Losing power overrides everything, including a same-cycle dismount.
            state_reg    <= OFF;
            ss_tmr_reg   <= '0;
            prescale_reg <= '0;
        end else begin
            prescale_reg <= prescale_reg + 8'd1;
            case (state_reg)
                OFF: begin
                    ss_tmr_reg <= '0;
                    state_reg  <= SOFT;
                end
                SOFT: begin
                    if (step && ss_tmr_reg != SS_MAX)
                        ss_tmr_reg <= ss_tmr_reg + SS_ONE;
                    if (rider_off)
                        state_reg <= DROP;
                    else if (ss_tmr_reg == SS_MAX)
                        state_reg <= RUN;
                end
                RUN: begin
                    ss_tmr_reg <= SS_MAX;
                    if (rider_off)
                        state_reg <= DROP;
                end
                DROP: begin
                    if (step && ss_tmr_reg != '0)
                        ss_tmr_reg <= ss_tmr_reg - SS_ONE;
                    if (!rider_off)
                        state_reg <= SOFT;
                end
                default: state_reg <= OFF;
            endcase
        end
    end

endmodule

// File: rtl/balance_cntrl_param.sv
// Balance controller: PID on pitch (stage 1), soft-start scaling and steering mix (stage 2),
// with hysteretic overspeed flag.
module balance_cntrl_param
    import balance_pkg::*;
#(
    parameter int PTCH_W    = 16,
    parameter int SPD_W     = 12,
    parameter int INTG_W    = 18,
    parameter int SS_W      = 9,
    parameter bit FAST_SIM  = 1'b1,
    parameter int P_COEFF   = 9,
    parameter int I_SHIFT   = 6,
    parameter int D_SHIFT   = 6,
    parameter int FAST_TH   = 1792,
    parameter int FAST_HYST = 128
) (
    input logic                   clk,
    input logic                   rst,
    balance_cntrl_param_if.slave  bus
);

    bal_state_t               state;
    logic [SS_W-1:0]          ss_tmr;
    logic signed [INTG_W-1:0] integ_reg;
    logic signed [INTG_W-1:0] integ_next;
    logic signed [SPD_W+1:0]  pid_q_reg;
    logic                     s1_vld_reg;
    logic                     spd_vld_reg;
    logic                     too_fast_reg;
    logic signed [SPD_W-1:0]  spd_reg  [2];
    logic signed [SPD_W-1:0]  spd_next [2];
    logic [1:0]               over;
    logic [1:0]               under;
    logic signed [31:0]       err;
    logic signed [31:0]       pid_full;
    logic signed [31:0]       scaled;
    logic signed [31:0]       steer;
    logic [11:0]              pot_clip;

    bal_soft_start #(
        .SS_W     (SS_W),
        .FAST_SIM (FAST_SIM)
    ) u_soft (
        .clk       (clk),
        .srst      (rst),
        .pwr_up    (bus.pwr_up),
        .rider_off (bus.rider_off),
        .state     (state),
        .ss_tmr    (ss_tmr)
    );

    assign err        = sat_s(32'($signed(bus.ptch[PTCH_W-1:0])), 10);
    assign integ_next = INTG_W'(sat_s(32'(integ_reg) + err, INTG_W));
    assign pid_full   = err * P_COEFF
                      + (32'(integ_reg) >>> I_SHIFT)
                      - (32'($signed(bus.ptch_rt[PTCH_W-1:0])) >>> D_SHIFT);

    assign scaled = (32'(pid_q_reg) * $signed({{(32-SS_W){1'b0}}, ss_tmr})) >>> SS_W;

    always_comb begin
        pot_clip = bus.steer_pot;
        if (bus.steer_pot < STEER_MIN)
            pot_clip = STEER_MIN;
        else if (bus.steer_pot > STEER_MAX)
            pot_clip = STEER_MAX;
    end

    assign steer = bus.en_steer
                 ? ((($signed({20'd0, pot_clip}) - $signed({20'd0, STEER_MID})) * 32'sd3) >>> 4)
                 : 32'sd0;

    // Channel 0 = left (adds steer), channel 1 = right (subtracts steer).
    for (genvar gi = 0; gi < 2; gi++) begin : g_mix
        logic signed [31:0] mixed;
        logic signed [31:0] mag;
        assign mixed         = (gi == 0) ? scaled + steer : scaled - steer;
        assign spd_next[gi]  = (state == OFF) ? '0 : SPD_W'(sat_s(mixed, SPD_W));
        assign mag           = abs_sat(32'(spd_next[gi]), SPD_W);
        assign over[gi]      = mag > FAST_TH;
        assign under[gi]     = mag < (FAST_TH - FAST_HYST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            integ_reg    <= '0;
            pid_q_reg    <= '0;
            s1_vld_reg   <= 1'b0;
            spd_vld_reg  <= 1'b0;
            too_fast_reg <= 1'b0;
            spd_reg[0]   <= '0;
            spd_reg[1]   <= '0;
        end else begin
            s1_vld_reg  <= bus.vld;
            spd_vld_reg <= s1_vld_reg;

            if (state == OFF || state == DROP)
                integ_reg <= '0;
            else if (state == RUN && bus.vld)
                integ_reg <= integ_next;

            // Stage 1 uses the integrator value from before this sample's accumulation.
            if (bus.vld)
                pid_q_reg <= (SPD_W+2)'(sat_s(pid_full, SPD_W + 2));

            if (s1_vld_reg) begin
                spd_reg[0] <= spd_next[0];
                spd_reg[1] <= spd_next[1];
                if (|over)
                    too_fast_reg <= 1'b1;
                else if (&under)
                    too_fast_reg <= 1'b0;
            end
        end
    end

    assign bus.lft_spd  = spd_reg[0];
    assign bus.rght_spd = spd_reg[1];
    assign bus.spd_vld  = spd_vld_reg;
    assign bus.too_fast = too_fast_reg;
    assign bus.ss_tmr   = ss_tmr;

endmodule

// File: tb/tb_balance_cntrl_param.sv
// Directed bench for balance_cntrl_param: reset, soft-start ramp, PID/steer vectors,
// integrator saturation, overspeed hysteresis, dismount and power-down.
module tb_balance_cntrl_param;
    import balance_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cnt;

    always #5 clk = ~clk;

    balance_cntrl_param_if #(.PTCH_W(16), .SPD_W(12), .SS_W(9)) bus ();

    balance_cntrl_param dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input longint obs, input longint exp_val);
        checks++;
        if (obs != exp_val) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp_val);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One vld sample; result is expected two clocks later.
    task automatic pulse(input string tag, input logic signed [15:0] p, input logic signed [15:0] r);
        bus.ptch    = p;
        bus.ptch_rt = r;
        bus.vld     = 1'b1;
        tick(1);
        bus.vld     = 1'b0;
        chk({tag, "_vld_t1"}, longint'(bus.spd_vld), 0);
        tick(1);
        chk({tag, "_vld_t2"}, longint'(bus.spd_vld), 1);
    endtask

    initial begin
        bus.vld       = 1'b0;
        bus.ptch      = '0;
        bus.ptch_rt   = '0;
        bus.pwr_up    = 1'b0;
        bus.rider_off = 1'b0;
        bus.steer_pot = 12'h800;
        bus.en_steer  = 1'b0;

        // Reset held 3 clocks with vld toggling
        for (int i = 0; i < 3; i++) begin
            bus.vld = ~bus.vld;
            tick(1);
            chk("rst_spd_vld", longint'(bus.spd_vld), 0);
        end
        bus.vld = 1'b0;
        rst     = 1'b0;
        tick(1);
        chk("rst_spd_vld_after", longint'(bus.spd_vld), 0);
        chk("rst_lft", longint'(bus.lft_spd), 0);
        chk("rst_rght", longint'(bus.rght_spd), 0);
        chk("rst_too_fast", longint'(bus.too_fast), 0);
        chk("rst_ss_tmr", longint'(bus.ss_tmr), 0);
        chk("rst_state", longint'(dut.state), longint'(OFF));

        // Power-up ramp: 1 clk into SOFT, then 511 increments
        bus.pwr_up = 1'b1;
        cnt = 0;
        while (bus.ss_tmr != 9'd511 && cnt < 600) begin
            tick(1);
            cnt++;
        end
        chk("ramp_clks", cnt, 512);
        chk("ramp_ss_max", longint'(bus.ss_tmr), 511);
        tick(1);
        chk("ramp_state_run", longint'(dut.state), longint'(RUN));

        // P only: 100*9*511>>9 = 898
        pulse("p100", 16'sd100, 16'sd0);
        chk("p100_lft", longint'(bus.lft_spd), 898);
        chk("p100_rght", longint'(bus.rght_spd), 898);
        tick(1);
        chk("p100_vld_t3", longint'(bus.spd_vld), 0);
        chk("p100_integ", longint'(dut.integ_reg), 100);

        // Steering: full right, full left (floor), disabled
        bus.en_steer  = 1'b1;
        bus.steer_pot = 12'hFFF;
        pulse("steer_hi", 16'sd0, 16'sd0);
        chk("steer_hi_lft", longint'(bus.lft_spd), 288);
        chk("steer_hi_rght", longint'(bus.rght_spd), -288);
        bus.steer_pot = 12'h000;
        pulse("steer_lo", 16'sd0, 16'sd0);
        chk("steer_lo_lft", longint'(bus.lft_spd), -288);
        chk("steer_lo_rght", longint'(bus.rght_spd), 288);
        bus.en_steer  = 1'b0;
        bus.steer_pot = 12'hFFF;
        pulse("steer_off", 16'sd0, 16'sd0);
        chk("steer_off_lft", longint'(bus.lft_spd), 0);
        chk("steer_off_rght", longint'(bus.rght_spd), 0);

        // Integrator saturation with back-to-back vld
        bus.ptch    = 16'sh7FFF;
        bus.ptch_rt = 16'sd0;
        bus.vld     = 1'b1;
        tick(1000);
        chk("pipe_spd_vld", longint'(bus.spd_vld), 1);
        tick(1000);
        bus.vld = 1'b0;
        tick(2);
        chk("sat_integ", longint'(dut.integ_reg), 131071);
        chk("sat_lft", longint'(bus.lft_spd), 2047);
        chk("sat_rght", longint'(bus.rght_spd), 2047);
        chk("sat_too_fast", longint'(bus.too_fast), 1);

        // Hysteresis: 2047-343=1704 -> 1700 holds; 2047-443=1604 -> 1600 clears
        pulse("hyst1700", 16'sd0, 16'sd21952);
        chk("hyst1700_lft", longint'(bus.lft_spd), 1700);
        chk("hyst1700_too_fast", longint'(bus.too_fast), 1);
        pulse("hyst1600", 16'sd0, 16'sd28352);
        chk("hyst1600_lft", longint'(bus.lft_spd), 1600);
        chk("hyst1600_too_fast", longint'(bus.too_fast), 0);

        // Rider dismount
        bus.rider_off = 1'b1;
        tick(1);
        chk("drop_state", longint'(dut.state), longint'(DROP));
        chk("drop_ss_hold", longint'(bus.ss_tmr), 511);
        tick(1);
        chk("drop_integ", longint'(dut.integ_reg), 0);
        chk("drop_ss_dec", longint'(bus.ss_tmr), 510);
        cnt = 0;
        while (bus.ss_tmr != 9'd0 && cnt < 600) begin
            tick(1);
            cnt++;
        end
        chk("drop_clks", cnt, 510);
        tick(3);
        chk("drop_ss_floor", longint'(bus.ss_tmr), 0);

        // Rider returns, then power lost mid-SOFT
        bus.rider_off = 1'b0;
        tick(1);
        chk("resoft_state", longint'(dut.state), longint'(SOFT));
        tick(5);
        chk("resoft_ss", longint'(bus.ss_tmr), 5);
        bus.pwr_up    = 1'b0;
        bus.rider_off = 1'b1;
        tick(1);
        chk("pwr_off_state", longint'(dut.state), longint'(OFF));
        chk("pwr_off_ss", longint'(bus.ss_tmr), 0);
        pulse("off", 16'sd100, 16'sd0);
        chk("off_lft", longint'(bus.lft_spd), 0);
        chk("off_rght", longint'(bus.rght_spd), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
